rv32v_sequencer: RTL

- Issue-side sequencer for the RV32V vector extension.
- Accepts one 32-bit OP-V instruction at a time and owns the VL CSR (0xC20), updating it on SETVL.
- Breaks each arithmetic, slide or FP vector instruction into LANES-wide element-group micro-ops, issued over valid/ready to the vector lanes.
- Sits between the scalar decode stage and the vector lane array; generalises the fixed RV32V encoding set to a configurable lane count and maximum vector length.

---
 rtl/rv32v_pkg.sv | 23 ++
 rtl/rv32v_legal_check.sv | 25 ++
 rtl/rv32v_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/rv32v_pkg.sv
// rv32v_pkg: RV32V encodings, sequencer state and micro-op field bundle.
package rv32v_pkg;
  localparam logic [11:0] RV32V_CSR_VL = 12'hC20;
  typedef enum logic [6:0] {OPC_V = 7'b1010111} rv32v_opcode_t;
  typedef enum logic [2:0] {
    F3_IVV = 3'd0, F3_FVV = 3'd1, F3_MVV = 3'd2, F3_IVI = 3'd3,
    F3_IVX = 3'd4, F3_FVF = 3'd5, F3_MVX = 3'd6, F3_SETVL = 3'd7
  } rv32v_funct3_t;
  typedef enum logic [5:0] {
    F6_VFADD = 6'b000000, F6_VFSUB = 6'b000010, F6_VSLIDEUP = 6'b001110,
    F6_VSLIDEDOWN = 6'b001111, F6_VFDIV = 6'b100000, F6_VFRDIV = 6'b100001,
    F6_VFMUL = 6'b100100
  } rv32v_funct6_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WB} rv32v_seq_state_t;
  typedef struct packed {
    logic [5:0]  funct6;
    logic [2:0]  funct3;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [31:0] scalar;
  } rv32v_uop_t;
endpackage

// File: rtl/rv32v_legal_check.sv
// rv32v_legal_check: funct3/funct6/vm legality table; masked ops legal only with RV32V_MASK_EN.
module rv32v_legal_check
  import rv32v_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [5:0] funct6,
  input  logic       vm,
  output logic       legal
);
  localparam logic MASK_EN =
`ifdef RV32V_MASK_EN
    1'b1;
`else
    1'b0;
`endif
  logic fp, slide;
  always_comb begin
    fp = funct6 inside {F6_VFADD, F6_VFSUB, F6_VFMUL, F6_VFDIV};
    slide = funct6 inside {F6_VSLIDEUP, F6_VSLIDEDOWN};
    legal = funct3 == F3_SETVL || ((vm || MASK_EN) &&
            ((fp && funct3 inside {F3_FVV, F3_FVF}) ||
             (funct6 == F6_VFRDIV && funct3 == F3_FVF) ||
             (slide && funct3 inside {F3_IVI, F3_IVX})));
  end
endmodule

// File: rtl/rv32v_sequencer.sv
// rv32v_sequencer: owns VL, splits vector ops into LANES-wide micro-ops.
// Optional RV32V_MASK_EN adds v0_mask and enables vm=0 instructions.
module rv32v_sequencer
  import rv32v_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int MAX_VL = 32,
  parameter int VL_W   = $clog2(MAX_VL + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [31:0]       inst,
  input  logic [31:0]       rs1_value,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              uop_valid,
  input  logic              uop_ready,
  output logic [5:0]        uop_funct6,
  output logic [2:0]        uop_funct3,
  output logic [4:0]        uop_vd,
  output logic [4:0]        uop_vs1,
  output logic [4:0]        uop_vs2,
  output logic [31:0]       uop_scalar,
  output logic [VL_W-1:0]   uop_base,
  output logic [LANES-1:0]  uop_lane_en,
  output logic              uop_last,
  output logic              illegal,
  output logic [VL_W-1:0]   vl
`ifdef RV32V_MASK_EN
  ,
  input  logic [MAX_VL-1:0] v0_mask
`endif
);
  rv32v_seq_state_t state;
  rv32v_uop_t uop_q;
  logic [VL_W-1:0] base, new_vl;
  logic [LANES-1:0] msk;
  logic legal;
  rv32v_legal_check u_legal (
    .funct3(inst[14:12]),
    .funct6(inst[31:26]),
    .vm    (inst[25]),
    .legal (legal)
  );
`ifdef RV32V_MASK_EN
  logic vm_q;
  assign msk = vm_q ? '1 : LANES'(v0_mask >> base);
`else
  assign msk = '1;
`endif
  assign new_vl = rs1_value > 32'(MAX_VL) ? VL_W'(MAX_VL) : VL_W'(rs1_value);
  assign inst_ready = state == IDLE;
  assign wb_valid = state == WB;
  assign uop_valid = state == ISSUE;
  assign uop_funct6 = uop_q.funct6;
  assign uop_funct3 = uop_q.funct3;
  assign uop_vd = uop_q.vd;
  assign uop_vs1 = uop_q.vs1;
  assign uop_vs2 = uop_q.vs2;
  assign uop_scalar = uop_q.scalar;
  assign uop_base = base;
  assign uop_last = state == ISSUE && int'(base) + LANES >= int'(vl);
  always_comb
    for (int i = 0; i < LANES; i++)
      uop_lane_en[i] = state == ISSUE && int'(base) + i < int'(vl) && msk[i];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      vl <= '0;
      base <= '0;
      uop_q <= '0;
      illegal <= 1'b0;
      wb_rd <= '0;
      wb_data <= '0;
`ifdef RV32V_MASK_EN
      vm_q <= 1'b1;
`endif
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE:
          if (inst_valid) begin
            if (inst[6:0] != OPC_V || !legal) illegal <= 1'b1;
            else if (inst[14:12] == F3_SETVL) begin
              vl <= new_vl;
              wb_rd <= inst[11:7];
              wb_data <= 32'(new_vl);
              state <= WB;
            end else if (vl != '0) begin
              uop_q <= '{funct6: inst[31:26], funct3: inst[14:12], vd: inst[11:7],
                         vs1: inst[19:15], vs2: inst[24:20],
                         scalar: inst[14:12] == F3_IVI ? {27'd0, inst[19:15]} : rs1_value};
`ifdef RV32V_MASK_EN
              vm_q <= inst[25];
`endif
              base <= '0;
              state <= ISSUE;
            end
          end
        ISSUE:
          if (uop_ready) begin
            if (uop_last) state <= IDLE;
            else base <= base + VL_W'(LANES);
          end
        WB: if (wb_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
